mc_control: RTL and testbench

Multi-cycle sequencer for the RV32I-subset datapath: steps each instruction through FETCH/DECODE/EXEC/MEM/WB and issues per-state enables and datapath selects. It sits beside the PC, IR, register file, ALU, IROM and DRAM. It also handshakes with IROM and DRAM through req/ready and traps on illegal opcodes or memory timeouts. Select encodings are the same as the existing single-cycle decode.

---
 rtl/mc_pkg.sv | 67 ++++++
 rtl/mc_control_if.sv | 11 +
 rtl/mc_decode.sv | 66 ++++++
 rtl/mc_control.sv | 184 ++++++++++++++++++
 tb/tb_mc_control.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle sequencer and its decoder.
package mc_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        CLS_R      = 3'd0,
        CLS_I      = 3'd1,
        CLS_LOAD   = 3'd2,
        CLS_STORE  = 3'd3,
        CLS_BRANCH = 3'd4,
        CLS_LUI    = 3'd5,
        CLS_JAL    = 3'd6,
        CLS_JALR   = 3'd7
    } cls_e;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SLL = 3'b001;
    localparam logic [2:0] ALU_SRA = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_OR  = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b111;

    localparam logic [1:0] WD_ALU  = 2'b00;
    localparam logic [1:0] WD_DRAM = 2'b01;
    localparam logic [1:0] WD_PC4  = 2'b10;
    localparam logic [1:0] WD_IMM  = 2'b11;

    localparam logic [1:0] NPC_PC4  = 2'b00;
    localparam logic [1:0] NPC_BR   = 2'b01;
    localparam logic [1:0] NPC_JAL  = 2'b10;
    localparam logic [1:0] NPC_JALR = 2'b11;

    localparam logic [2:0] SEXT_I = 3'b000;
    localparam logic [2:0] SEXT_S = 3'b001;
    localparam logic [2:0] SEXT_B = 3'b010;
    localparam logic [2:0] SEXT_U = 3'b011;
    localparam logic [2:0] SEXT_J = 3'b100;

    // fun3 maps straight onto the ALU code except where fun7[5] picks sub/sra.
    function automatic logic [2:0] alu_from_fun(input logic [2:0] fun3, input logic alt);
        case (fun3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            default: return fun3;
        endcase
    endfunction

endpackage

// File: rtl/mc_control_if.sv
// Instruction/data memory request-ready handshake seen by the sequencer.
interface mc_control_if;
    logic irom_req;
    logic irom_ready;
    logic dram_req;
    logic dram_we;
    logic dram_ready;

    modport master (output irom_req, dram_req, dram_we, input irom_ready, dram_ready);
    modport slave  (input irom_req, dram_req, dram_we, output irom_ready, dram_ready);
endinterface

// File: rtl/mc_decode.sv
// Combinational decode of opcode/fun3/fun7 into legality, class and datapath selects.
module mc_decode
    import mc_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] fun3_i,
    input  logic       fun7_b5_i,
    output logic       legal_o,
    output cls_e       cls_o,
    output logic [2:0] alu_op_o,
    output logic       b_sel_o,
    output logic [2:0] sext_sel_o,
    output logic [1:0] wd_sel_o
);

    always_comb begin
        legal_o    = 1'b1;
        cls_o      = CLS_R;
        alu_op_o   = ALU_ADD;
        b_sel_o    = 1'b1;
        sext_sel_o = SEXT_I;
        wd_sel_o   = WD_ALU;
        case (opcode_i)
            OPC_R: begin
                b_sel_o  = 1'b0;
                alu_op_o = alu_from_fun(fun3_i, fun7_b5_i);
            end
            OPC_I: begin
                cls_o    = CLS_I;
                alu_op_o = (fun3_i == 3'b000) ? ALU_ADD : alu_from_fun(fun3_i, fun7_b5_i);
            end
            OPC_LOAD: begin
                cls_o    = CLS_LOAD;
                wd_sel_o = WD_DRAM;
            end
            OPC_STORE: begin
                cls_o      = CLS_STORE;
                sext_sel_o = SEXT_S;
            end
            OPC_BRANCH: begin
                cls_o      = CLS_BRANCH;
                b_sel_o    = 1'b0;
                alu_op_o   = ALU_SUB;
                sext_sel_o = SEXT_B;
                legal_o    = (fun3_i == 3'b000) || (fun3_i == 3'b001) ||
                             (fun3_i == 3'b100) || (fun3_i == 3'b101);
            end
            OPC_LUI: begin
                cls_o      = CLS_LUI;
                sext_sel_o = SEXT_U;
                wd_sel_o   = WD_IMM;
            end
            OPC_JAL: begin
                cls_o      = CLS_JAL;
                sext_sel_o = SEXT_J;
                wd_sel_o   = WD_PC4;
            end
            OPC_JALR: begin
                cls_o    = CLS_JALR;
                wd_sel_o = WD_PC4;
            end
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory timeout trap.
// Optional MC_PERF_CNT_EN adds cycle_cnt/instret_cnt performance counters.
module mc_control
    import mc_pkg::*;
#(
    parameter int unsigned TIMEOUT = 0,
    parameter int unsigned CNT_W   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    mc_control_if.master bus,
    input  logic [6:0] opcode,
    input  logic [2:0] fun3,
    input  logic [6:0] fun7,
    input  logic       alu_zero,
    input  logic       alu_lt,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] npc_op,
    output logic       rf_we,
    output logic [1:0] wd_sel,
    output logic       b_sel,
    output logic [2:0] alu_op,
    output logic [2:0] sext_sel,
    output logic       trap,
    output logic [2:0] state_o
`ifdef MC_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);

    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       dec_legal, dec_b_sel;
    cls_e       dec_cls;
    logic [2:0] dec_alu_op, dec_sext_sel;
    logic [1:0] dec_wd_sel;
    logic       fun7_unused;

    logic       irom_req_c, ir_we_c, pc_we_c, rf_we_c, dram_req_c, dram_we_c;
    logic [1:0] npc_c;
    logic       sel_en, waiting, timed_out, br_taken;

    assign fun7_unused = ^{fun7[6], fun7[4:0]};

    mc_decode u_decode (
        .opcode_i   (opcode),
        .fun3_i     (fun3),
        .fun7_b5_i  (fun7[5]),
        .legal_o    (dec_legal),
        .cls_o      (dec_cls),
        .alu_op_o   (dec_alu_op),
        .b_sel_o    (dec_b_sel),
        .sext_sel_o (dec_sext_sel),
        .wd_sel_o   (dec_wd_sel)
    );

    assign timed_out = (TIMEOUT != 0) && (cnt_q == TO_LIM);

    always_comb begin
        case (fun3)
            3'b000:  br_taken = alu_zero;
            3'b001:  br_taken = !alu_zero;
            3'b100:  br_taken = alu_lt;
            default: br_taken = !alu_lt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        irom_req_c = 1'b0;
        ir_we_c    = 1'b0;
        pc_we_c    = 1'b0;
        rf_we_c    = 1'b0;
        dram_req_c = 1'b0;
        dram_we_c  = 1'b0;
        npc_c      = NPC_PC4;
        sel_en     = 1'b0;
        waiting    = 1'b0;
        case (state_q)
            FETCH: begin
                irom_req_c = 1'b1;
                if (bus.irom_ready) begin
                    ir_we_c = 1'b1;
                    state_d = DECODE;
                end else begin
                    waiting = 1'b1;
                    if (timed_out) state_d = TRAP;
                end
            end
            DECODE: state_d = dec_legal ? EXEC : TRAP;
            EXEC: begin
                sel_en = 1'b1;
                case (dec_cls)
                    CLS_BRANCH: begin
                        pc_we_c = 1'b1;
                        npc_c   = br_taken ? NPC_BR : NPC_PC4;
                        state_d = FETCH;
                    end
                    CLS_LOAD, CLS_STORE: state_d = MEM;
                    default:             state_d = WB;
                endcase
            end
            MEM: begin
                sel_en     = 1'b1;
                dram_req_c = 1'b1;
                dram_we_c  = (dec_cls == CLS_STORE);
                if (bus.dram_ready) begin
                    if (dec_cls == CLS_STORE) begin
                        pc_we_c = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end else begin
                    waiting = 1'b1;
                    if (timed_out) state_d = TRAP;
                end
            end
            WB: begin
                sel_en  = 1'b1;
                rf_we_c = 1'b1;
                pc_we_c = 1'b1;
                if (dec_cls == CLS_JAL)       npc_c = NPC_JAL;
                else if (dec_cls == CLS_JALR) npc_c = NPC_JALR;
                state_d = FETCH;
            end
            TRAP:    state_d = TRAP;
            default: state_d = TRAP;
        endcase

        // Counter measures time spent waiting in the current state only.
        if (state_d != state_q)            cnt_d = '0;
        else if (waiting && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
        else                               cnt_d = cnt_q;
    end

    assign bus.irom_req = rst_n & irom_req_c;
    assign bus.dram_req = rst_n & dram_req_c;
    assign bus.dram_we  = rst_n & dram_we_c;
    assign ir_we        = rst_n & ir_we_c;
    assign pc_we        = rst_n & pc_we_c;
    assign rf_we        = rst_n & rf_we_c;
    assign npc_op       = rst_n ? npc_c : NPC_PC4;
    assign trap         = rst_n & (state_q == TRAP);
    assign alu_op       = sel_en ? dec_alu_op : 3'b000;
    assign b_sel        = sel_en & dec_b_sel;
    assign sext_sel     = sel_en ? dec_sext_sel : 3'b000;
    assign wd_sel       = sel_en ? dec_wd_sel : 2'b00;
    assign state_o      = state_q;

`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_q, instret_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (pc_we) instret_q <= instret_q + 32'd1;
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
`endif

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control (TIMEOUT=8): directed test-plan steps plus random instructions
// checked cycle by cycle against a per-instruction schedule model.
module tb_mc_control;

    localparam int TMO = 8;
    localparam int S_F = 0, S_D = 1, S_E = 2, S_M = 3, S_W = 4, S_T = 7;
    localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_LUI = 5, K_JAL = 6, K_JALR = 7;

    logic       clk, rst_n;
    logic [6:0] opcode, fun7;
    logic [2:0] fun3;
    logic       alu_zero, alu_lt;
    logic       ir_we, pc_we, rf_we, b_sel, trap;
    logic [1:0] npc_op, wd_sel;
    logic [2:0] alu_op, sext_sel, state_o;
`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    mc_control_if bus ();

    mc_control #(.TIMEOUT(TMO), .CNT_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.master),
        .opcode   (opcode),
        .fun3     (fun3),
        .fun7     (fun7),
        .alu_zero (alu_zero),
        .alu_lt   (alu_lt),
        .ir_we    (ir_we),
        .pc_we    (pc_we),
        .npc_op   (npc_op),
        .rf_we    (rf_we),
        .wd_sel   (wd_sel),
        .b_sel    (b_sel),
        .alu_op   (alu_op),
        .sext_sel (sext_sel),
        .trap     (trap),
        .state_o  (state_o)
`ifdef MC_PERF_CNT_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Expected decode of the instruction currently being sequenced.
    logic       e_legal;
    int         e_kind;
    logic [2:0] e_alu, e_sext;
    logic       e_bsel;
    logic [1:0] e_wd;

    logic [6:0] legal_ops [8];

    task automatic chk(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
        end
    endtask

    // Checks one clock cycle of outputs, then advances to just after the next edge.
    task automatic cyc(input string tag, input int st, input int irq, input int iwe, input int pwe,
                       input int npc, input int rwe, input int drq, input int dwe, input int trp,
                       input int selon);
        #1;
        chk(tag, "state",    state_o,          st);
        chk(tag, "irom_req", bus.irom_req,     irq);
        chk(tag, "ir_we",    ir_we,            iwe);
        chk(tag, "pc_we",    pc_we,            pwe);
        chk(tag, "npc_op",   npc_op,           npc);
        chk(tag, "rf_we",    rf_we,            rwe);
        chk(tag, "dram_req", bus.dram_req,     drq);
        chk(tag, "dram_we",  bus.dram_we,      dwe);
        chk(tag, "trap",     trap,             trp);
        chk(tag, "alu_op",   alu_op,   selon ? e_alu  : 0);
        chk(tag, "b_sel",    b_sel,    selon ? e_bsel : 0);
        chk(tag, "sext_sel", sext_sel, selon ? e_sext : 0);
        chk(tag, "wd_sel",   wd_sel,   selon ? e_wd   : 0);
        @(posedge clk);
        #1;
    endtask

    // Reference decode, straight from the instruction-set rules.
    task automatic model(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        e_legal = 1'b1; e_alu = 3'd0; e_bsel = 1'b1; e_sext = 3'd0; e_wd = 2'd0; e_kind = K_R;
        case (op)
            7'b0110011: begin
                e_kind = K_R; e_bsel = 1'b0;
                if (f3 == 3'd0)      e_alu = f7[5] ? 3'd3 : 3'd0;
                else if (f3 == 3'd5) e_alu = f7[5] ? 3'd2 : 3'd5;
                else                 e_alu = f3;
            end
            7'b0010011: begin
                e_kind = K_I;
                if (f3 == 3'd5)      e_alu = f7[5] ? 3'd2 : 3'd5;
                else if (f3 != 3'd0) e_alu = f3;
            end
            7'b0000011: begin e_kind = K_LD;  e_wd = 2'd1; end
            7'b0100011: begin e_kind = K_ST;  e_sext = 3'd1; end
            7'b1100011: begin
                e_kind = K_BR; e_bsel = 1'b0; e_alu = 3'd3; e_sext = 3'd2;
                e_legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd4) || (f3 == 3'd5);
            end
            7'b0110111: begin e_kind = K_LUI;  e_sext = 3'd3; e_wd = 2'd3; end
            7'b1101111: begin e_kind = K_JAL;  e_sext = 3'd4; e_wd = 2'd2; end
            7'b1100111: begin e_kind = K_JALR; e_wd = 2'd2; end
            default: e_legal = 1'b0;
        endcase
    endtask

    task automatic trap_phase(input string tag, input int hold);
        for (int h = 0; h < hold; h++) cyc({tag, ".T"}, S_T, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        rst_n = 1'b0;
        cyc({tag, ".Trst"}, S_T, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
    endtask

    // iw/dw: non-ready cycles before ready in FETCH/MEM; rst_at: MEM cycle at which reset is pulled.
    task automatic do_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                            input logic [6:0] f7, input logic z, input logic lt,
                            input int iw, input int dw, input int rst_at, input int hold);
        int   c;
        logic done, trapped, rdy, taken, is_st;
        $display("instr %s op=%b f3=%b f7=%b z=%0d lt=%0d iw=%0d dw=%0d", tag, op, f3, f7, z, lt, iw, dw);
        model(op, f3, f7);
        opcode = op; fun3 = f3; fun7 = f7; alu_zero = z; alu_lt = lt;
        c = 0; done = 0; trapped = 0;
        while (!done) begin
            rdy = (c == iw);
            bus.irom_ready = rdy;
            cyc({tag, ".F"}, S_F, 1, rdy, 0, 0, 0, 0, 0, 0, 0);
            if (rdy) done = 1;
            else if (c == TMO) begin done = 1; trapped = 1; end
            c++;
        end
        bus.irom_ready = 1'b0;
        if (trapped) begin trap_phase(tag, hold); return; end
        cyc({tag, ".D"}, S_D, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        if (!e_legal) begin trap_phase(tag, hold); return; end
        if (e_kind == K_BR) begin
            case (f3)
                3'd0:    taken = z;
                3'd1:    taken = !z;
                3'd4:    taken = lt;
                default: taken = !lt;
            endcase
            cyc({tag, ".E"}, S_E, 0, 0, 1, taken ? 1 : 0, 0, 0, 0, 0, 1);
            return;
        end
        cyc({tag, ".E"}, S_E, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        if (e_kind == K_LD || e_kind == K_ST) begin
            is_st = (e_kind == K_ST);
            c = 0; done = 0;
            while (!done) begin
                if (c == rst_at) begin
                    rst_n = 1'b0;
                    bus.dram_ready = 1'b0;
                    cyc({tag, ".Mrst"}, S_M, 0, 0, 0, 0, 0, 0, 0, 0, 1);
                    rst_n = 1'b1;
                    return;
                end
                rdy = (c == dw);
                bus.dram_ready = rdy;
                cyc({tag, ".M"}, S_M, 0, 0, (rdy && is_st) ? 1 : 0, 0, 0, 1, is_st, 0, 1);
                if (rdy) done = 1;
                else if (c == TMO) begin done = 1; trapped = 1; end
                c++;
            end
            bus.dram_ready = 1'b0;
            if (trapped) begin trap_phase(tag, hold); return; end
            if (is_st) return;
        end
        cyc({tag, ".W"}, S_W, 0, 0, 1, (e_kind == K_JAL) ? 2 : (e_kind == K_JALR) ? 3 : 0, 1, 0, 0, 0, 1);
    endtask

    initial begin
        logic [6:0] op, f7;
        logic [2:0] f3;
        int         iw, dw;

        legal_ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                      7'b1100011, 7'b0110111, 7'b1101111, 7'b1100111};
        rst_n = 1'b0; opcode = '0; fun3 = '0; fun7 = '0; alu_zero = 1'b0; alu_lt = 1'b0;
        bus.irom_ready = 1'b0; bus.dram_ready = 1'b0;
        e_alu = '0; e_bsel = 1'b0; e_sext = '0; e_wd = '0; e_legal = 1'b0; e_kind = K_R;

        @(posedge clk);
        #1;
        cyc("reset", S_F, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        do_instr("sub",      7'b0110011, 3'b000, 7'b0100000, 0, 0, 0, 0, -1, 2);
        do_instr("lw",       7'b0000011, 3'b010, 7'b0000000, 0, 0, 0, 3, -1, 2);
        do_instr("beq",      7'b1100011, 3'b000, 7'b0000000, 1, 0, 0, 0, -1, 2);
        do_instr("bge",      7'b1100011, 3'b101, 7'b0000000, 0, 1, 0, 0, -1, 2);
        do_instr("ill_op",   7'b0000000, 3'b000, 7'b0000000, 0, 0, 0, 0, -1, 20);
        do_instr("ill_br",   7'b1100011, 3'b010, 7'b0000000, 0, 0, 0, 0, -1, 20);
        do_instr("to_stuck", 7'b0110011, 3'b000, 7'b0000000, 0, 0, 100, 0, -1, 3);
        do_instr("to_edge",  7'b0110011, 3'b111, 7'b0000000, 0, 0, TMO, 0, -1, 3);
        do_instr("sw_rst",   7'b0100011, 3'b010, 7'b0000000, 0, 0, 0, 5, 2, 2);
        do_instr("jal",      7'b1101111, 3'b000, 7'b0000000, 0, 0, 1, 0, -1, 2);
        do_instr("jalr",     7'b1100111, 3'b000, 7'b0000000, 0, 0, 0, 0, -1, 2);
        do_instr("lui",      7'b0110111, 3'b000, 7'b0000000, 0, 0, 0, 0, -1, 2);
        do_instr("srai",     7'b0010011, 3'b101, 7'b0100000, 0, 0, 0, 0, -1, 2);
        do_instr("sw_to",    7'b0100011, 3'b010, 7'b0000000, 0, 0, 0, 50, -1, 2);

        for (int n = 0; n < 60; n++) begin
            op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : legal_ops[$urandom_range(0, 7)];
            f3 = 3'($urandom);
            f7 = 7'($urandom);
            iw = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 10) : $urandom_range(0, 2);
            dw = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 10) : $urandom_range(0, 2);
            do_instr("rnd", op, f3, f7, 1'($urandom), 1'($urandom), iw, dw, -1, 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
